gcd_control: RTL and testbench
==============================

# gcd_control

Control unit for the GCD datapath; the other end of its control/status interface. Owns the operand/result valid/ready handshakes and drives the datapath enables and selects from the `B_zero` and `A_lt_B` status flags. It runs Euclid's algorithm by subtraction and swap. The datapath and this block are instantiated side by side by the GCD top level; this block contains no data registers of width W.

## Interface

Parameters:
- `CW`, default 8: width of the iteration counter.

Ports:
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `operand_val`  input  1  upstream has operands valid on the datapath `operand_A`/`operand_B`.
- `operand_rdy`  output  1  block accepts operands this cycle.
- `result_val`  output  1  datapath `result_data` holds the final GCD.
- `result_rdy`  input  1  downstream accepts the result.
- `B_zero`  input  1  datapath status, B == 0.
- `A_lt_B`  input  1  datapath status, A < B.
- `A_en`  output  1  datapath A register load enable.
- `B_en`  output  1  datapath B register load enable.
- `A_sel`  output  2  A mux select: 0 = operand_A, 1 = B, 2 = A−B; 3 is never driven.
- `B_sel`  output  1  B mux select: 0 = operand_B, 1 = A.
- `iter_count`  output  CW  swap plus subtract steps used by the current or most recent operation.

## Operation

- There are three states: IDLE, CALC and DONE, with a 2-bit state register. Handshake and datapath outputs are decoded combinationally from the state and inputs.
- IDLE:
  - `operand_rdy`=1, `result_val`=0.
  - `A_en`=`B_en`=`operand_val`, `A_sel`=0, `B_sel`=0.
  - On operand fire (`operand_val`&`operand_rdy`): go to CALC and clear `iter_count` to 0.
- CALC: `operand_rdy`=0, `result_val`=0. The cases below are checked in priority order.
  - `A_lt_B`=1 (swap): `A_en`=1, `B_en`=1, `A_sel`=1, `B_sel`=1. Stay in CALC and increment `iter_count`.
  - else `B_zero`=0 (subtract): `A_en`=1, `B_en`=0, `A_sel`=2, `B_sel`=0. Stay in CALC and increment `iter_count`.
  - else (B==0, A≥B): `A_en`=`B_en`=0, `A_sel`=0, `B_sel`=0. Go to DONE; `iter_count` is unchanged.
- DONE:
  - `result_val`=1, `operand_rdy`=0.
  - `A_en`=`B_en`=0, `A_sel`=0, `B_sel`=0, so `result_data` (datapath A) stays stable under backpressure.
  - On `result_rdy`=1: go to IDLE.
  - Stays in DONE indefinitely while `result_rdy`=0.
- `iter_count`:
  - Saturates at 2^CW−1 and never wraps.
  - Holds its value through DONE and IDLE until the next operand fire.
- The unused state encoding decodes as IDLE outputs and transitions to IDLE on the next edge.
- A result and a new operand cannot be exchanged in the same cycle. After the DONE→IDLE edge, at least one IDLE cycle occurs before the next fire.

## Timing

- Reset (`rst_n`=0), applied immediately and asynchronously:
  - state=IDLE, `iter_count`=0.
  - `result_val`=0, `operand_rdy`=1.
  - `A_en`=`B_en`=`operand_val`, selects 0.
- Reset deassertion is synchronised by the integrator; the block needs no extra cycles after `rst_n` rises.
- Reset mid-CALC or mid-DONE abandons the operation. `result_val` drops in the same cycle, with no glitch-free requirement. The datapath contents are then don't-care.
- Latency in cycles:
  - Fire edge → CALC.
  - N work cycles (N = final `iter_count`).
  - 1 terminating CALC cycle.
  - `result_val` high from the edge that closes the terminating cycle.
  - Total: `result_val` rises N+2 rising edges after the fire edge.
- `result_val` and `operand_rdy` are never both 1.
- Outputs are combinational from registered state plus `operand_val`/`B_zero`/`A_lt_B`; there are no combinational paths from `result_rdy`.

## Test plan

- gcd(15,5), `result_rdy`=1:
  - step sequence sub, sub, sub, swap;
  - `iter_count`=4, `result_data`=5;
  - `result_val` 6 edges after fire;
  - then IDLE with `operand_rdy`=1.
- Zero operands:
  - gcd(0,0): DONE after 1 CALC cycle, `result_data`=0, `iter_count`=0.
  - gcd(9,0): `result_data`=9, `iter_count`=0.
  - gcd(0,7): one swap, `result_data`=7, `iter_count`=1.
- Backpressure: gcd(12,18) with `result_rdy` held low 10 cycles:
  - `result_val` stays 1;
  - `A_en`=`B_en`=0 throughout;
  - `result_data` holds 6;
  - release → IDLE next edge.
- Saturation: CW=4, gcd(200,1) (W=8) → `iter_count` stays 15, `result_data`=1.
- Reset mid-CALC: pull `rst_n` low during gcd(200,1):
  - `iter_count`=0 and `operand_rdy`=1 without waiting for a clock;
  - a following gcd(27,36)=9 completes correctly.
- Back-to-back: three operations with `operand_val` and `result_rdy` tied high:
  - correct results;
  - `operand_rdy`&`result_val` never both 1;
  - exactly one IDLE cycle between results.

Source files
------------

// File: rtl/gcd_control.sv
// gcd_control: sequences the GCD datapath through Euclid's
// subtract/swap loop and owns the operand/result handshakes.
module gcd_control #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          operand_val,
  output logic          operand_rdy,
  output logic          result_val,
  input  logic          result_rdy,
  input  logic          B_zero,
  input  logic          A_lt_B,
  output logic          A_en,
  output logic          B_en,
  output logic [1:0]    A_sel,
  output logic          B_sel,
  output logic [CW-1:0] iter_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] SEL_OP  = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_SUB = 2'd2;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step        = 1'b0;
    operand_rdy = 1'b0;
    result_val  = 1'b0;
    A_en        = 1'b0;
    B_en        = 1'b0;
    A_sel       = SEL_OP;
    B_sel       = 1'b0;
    unique case (state_q)
      IDLE: begin
        operand_rdy = 1'b1;
        A_en        = operand_val;
        B_en        = operand_val;
        if (operand_val) begin
          state_d = CALC;
          cnt_d   = '0;
        end
      end
      CALC: begin
        priority case (1'b1)
          A_lt_B: begin
            A_en  = 1'b1;
            B_en  = 1'b1;
            A_sel = SEL_B;
            B_sel = 1'b1;
            step  = 1'b1;
          end
          !B_zero: begin
            A_en  = 1'b1;
            A_sel = SEL_SUB;
            step  = 1'b1;
          end
          default: state_d = DONE;
        endcase
      end
      DONE: begin
        result_val = 1'b1;
        if (result_rdy) state_d = IDLE;
      end
      default: begin
        // Stray encoding: present IDLE outputs, recover without firing
        operand_rdy = 1'b1;
        A_en        = operand_val;
        B_en        = operand_val;
        state_d     = IDLE;
      end
    endcase
    if (step && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  assign iter_count = cnt_q;

endmodule

// File: tb/tb_gcd_control.sv
// tb_gcd_control: drives gcd_control against a behavioural
// datapath and an arithmetic Euclid schedule model.
module tb_gcd_control;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk;
  logic          rst_n;
  logic          operand_val;
  logic          operand_rdy;
  logic          result_val;
  logic          result_rdy;
  logic          B_zero;
  logic          A_lt_B;
  logic          A_en;
  logic          B_en;
  logic [1:0]    A_sel;
  logic          B_sel;
  logic [CW-1:0] iter_count;

  logic [7:0] operand_A, operand_B;
  logic [7:0] dA, dB;
  logic [7:0] result_data;
  logic [4:0] ctl;

  int checks = 0;
  int errors = 0;

  gcd_control #(.CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .operand_val (operand_val),
    .operand_rdy (operand_rdy),
    .result_val  (result_val),
    .result_rdy  (result_rdy),
    .B_zero      (B_zero),
    .A_lt_B      (A_lt_B),
    .A_en        (A_en),
    .B_en        (B_en),
    .A_sel       (A_sel),
    .B_sel       (B_sel),
    .iter_count  (iter_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath stand-in driven by the controller's enables/selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dA <= '0;
      dB <= '0;
    end else begin
      if (A_en) begin
        case (A_sel)
          2'd0:    dA <= operand_A;
          2'd1:    dA <= dB;
          2'd2:    dA <= dA - dB;
          default: dA <= dA;
        endcase
      end
      if (B_en) dB <= B_sel ? dA : operand_B;
    end
  end

  assign B_zero      = (dB == 8'd0);
  assign A_lt_B      = (dA < dB);
  assign result_data = dA;
  assign ctl         = {A_en, B_en, A_sel, B_sel};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gcd_mod(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  logic [4:0] sched[$];
  int         n_steps;
  int         exp_res;
  int         exp_cnt;
  int         mode;
  int         k;
  logic [4:0] e;

  // Expected per-cycle control word for the whole operation
  task automatic build(input int a0, input int b0);
    int a, b, t;
    a = a0;
    b = b0;
    sched.delete();
    while (1) begin
      if (a < b) begin
        t = a;
        a = b;
        b = t;
        sched.push_back(5'b11011);
      end else if (b != 0) begin
        a = a - b;
        sched.push_back(5'b10100);
      end else begin
        break;
      end
    end
    n_steps = sched.size();
    sched.push_back(5'b00000);
    exp_res = a;
  endtask

  initial begin
    mode    = M_IDLE;
    exp_cnt = 0;
    k       = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mode    = M_IDLE;
        exp_cnt = 0;
        sched.delete();
      end else begin
        chk("excl", int'(operand_rdy & result_val), 0);
        case (mode)
          M_IDLE: begin
            chk("idle_rdy", operand_rdy, 1);
            chk("idle_val", result_val, 0);
            chk("idle_ctl", ctl, {operand_val, operand_val, 3'b000});
            chk("idle_cnt", iter_count, exp_cnt);
            if (operand_val) begin
              build(operand_A, operand_B);
              k    = 0;
              mode = M_RUN;
            end
          end
          M_RUN: begin
            e = sched.pop_front();
            chk("run_hs", {operand_rdy, result_val}, 0);
            chk("run_ctl", ctl, e);
            chk("run_cnt", iter_count, sat(k));
            k++;
            if (sched.size() == 0) begin
              exp_cnt = sat(n_steps);
              mode    = M_DONE;
            end
          end
          default: begin
            chk("done_val", result_val, 1);
            chk("done_rdy", operand_rdy, 0);
            chk("done_ctl", ctl, 0);
            chk("done_res", result_data, exp_res);
            chk("done_cnt", iter_count, exp_cnt);
            if (result_rdy) mode = M_IDLE;
          end
        endcase
      end
    end
  end

  // Entered and left at posedge+1
  task automatic run_op(input int a, input int b, input int hold,
                        input int er, input int ec, input int el);
    int t, lat;
    operand_A   = a[7:0];
    operand_B   = b[7:0];
    operand_val = 1'b1;
    result_rdy  = (hold == 0);
    t = 0;
    @(negedge clk);
    while (!operand_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!operand_rdy) begin
      chk("fire_timeout", 0, 1);
      operand_val = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    operand_val = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!result_val && lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!result_val) begin
      chk("done_timeout", 0, 1);
      result_rdy = 1'b0;
      @(posedge clk); #1;
      return;
    end
    if (el >= 0) chk("latency", lat, el);
    if (er >= 0) chk("result", result_data, er);
    if (ec >= 0) chk("iter", iter_count, ec);
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        chk("bp_val", result_val, 1);
        chk("bp_en", {A_en, B_en}, 0);
        chk("bp_res", result_data, er);
      end
      @(posedge clk); #1;
      result_rdy = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    result_rdy = 1'b0;
    @(negedge clk);
    chk("post_idle", operand_rdy, 1);
    @(posedge clk); #1;
  endtask

  task automatic b2b();
    int ea[3], eb[3];
    int fires, results, idle, t;
    logic fire;
    ea = '{48, 7, 100};
    eb = '{18, 5, 75};
    fires = 0;
    results = 0;
    idle = 0;
    t = 0;
    operand_A   = 8'd48;
    operand_B   = 8'd18;
    operand_val = 1'b1;
    result_rdy  = 1'b1;
    while (results < 3 && t < 2000) begin
      @(negedge clk);
      t++;
      if (operand_rdy) idle++;
      if (result_val) begin
        chk("b2b_res", result_data, gcd_mod(ea[results], eb[results]));
        if (results > 0) chk("b2b_gap", idle, 1);
        idle = 0;
        results++;
      end
      fire = operand_rdy && operand_val;
      @(posedge clk); #1;
      if (fire) begin
        fires++;
        if (fires < 3) begin
          operand_A = ea[fires][7:0];
          operand_B = eb[fires][7:0];
        end else begin
          operand_val = 1'b0;
        end
      end
    end
    if (results < 3) chk("b2b_timeout", results, 3);
    operand_val = 1'b0;
    result_rdy  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, hold, gap;
    rst_n       = 1'b0;
    operand_val = 1'b0;
    result_rdy  = 1'b0;
    operand_A   = '0;
    operand_B   = '0;
    #3;
    chk("rst_rdy", operand_rdy, 1);
    chk("rst_val", result_val, 0);
    chk("rst_cnt", iter_count, 0);
    chk("rst_en0", {A_en, B_en}, 0);
    operand_val = 1'b1;
    #1;
    chk("rst_en1", ctl, 5'b11000);
    operand_val = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(15, 5, 0, 5, 4, 6);
    run_op(0, 0, 0, 0, 0, 2);
    run_op(9, 0, 0, 9, 0, 2);
    run_op(0, 7, 0, 7, 1, 3);
    run_op(12, 18, 10, 6, 6, 8);
    run_op(200, 1, 0, 1, 15, 203);

    // Abandon gcd(200,1) with an asynchronous reset mid-CALC
    operand_A   = 8'd200;
    operand_B   = 8'd1;
    operand_val = 1'b1;
    result_rdy  = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    operand_val = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("pre_rst_cnt", iter_count, 15);
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", iter_count, 0);
    chk("arst_rdy", operand_rdy, 1);
    chk("arst_val", result_val, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    result_rdy = 1'b0;
    @(posedge clk); #1;
    run_op(27, 36, 0, 9, 7, 9);

    b2b();
    @(posedge clk); #1;

    for (int i = 0; i < 25; i++) begin
      a    = $urandom_range(0, 255);
      b    = $urandom_range(0, 255);
      hold = $urandom_range(0, 3);
      gap  = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      run_op(a, b, hold, gcd_mod(a, b), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
